// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage with req/ack imem port, one-entry skid buffer and branch redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, SKID = 2'd2, KILL = 2'd3;
  logic [1:0]  state;
  logic [31:0] fetch_pc, kill_pc, skid_instr, skid_pc;
  logic        ack, free;
  assign imem_req_o  = state == WAIT || state == KILL;
  assign imem_addr_o = state == KILL ? kill_pc : fetch_pc;
  assign ack         = imem_ack_i && imem_req_o;
  assign free        = !instr_valid_o || !stall_i;
  assign instr_op_o  = instr_o[31:26];
  assign pc_plus4_o  = pc_o + 32'd4;
  // Fetch FSM, output register and skid; redirect overrides all; KILL keeps the stale address on the bus until its ack
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      kill_pc       <= RESET_PC;
      instr_o       <= '0;
      pc_o          <= '0;
      instr_valid_o <= 1'b0;
      skid_instr    <= '0;
      skid_pc       <= '0;
    end else if (redirect_i) begin
      fetch_pc      <= redirect_pc_i & ~32'd3;
      instr_valid_o <= 1'b0;
      state         <= (state == WAIT && !ack) || state == KILL ? KILL : WAIT;
      if (state == WAIT) kill_pc <= fetch_pc;
    end else begin
      if (instr_valid_o && !stall_i) instr_valid_o <= 1'b0;
      case (state)
        IDLE: state <= WAIT;
        WAIT:
          if (ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (free) begin
              instr_o       <= imem_data_i;
              pc_o          <= fetch_pc;
              instr_valid_o <= 1'b1;
            end else begin
              skid_instr <= imem_data_i;
              skid_pc    <= fetch_pc;
              state      <= SKID;
            end
          end
        SKID:
          if (!stall_i) begin
            instr_o       <= skid_instr;
            pc_o          <= skid_pc;
            instr_valid_o <= 1'b1;
            state         <= WAIT;
          end
        default: if (ack) state <= WAIT;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed test-plan steps then randomized traffic against an in-order PC stream model
module tb_instr_fetch_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0, instr_valid, stall = 1'b0, redirect = 1'b0;
  logic [31:0] imem_addr, imem_data = '0, instr, pc, pc_plus4, redirect_pc = '0;
  logic [5:0]  instr_op;
  int          checks = 0, errors = 0, wcnt, dly, n;
  logic [31:0] exp_pc, raddr, tgt;
  bit          dirty, redir;

  instr_fetch_unit dut (
    .clk_i(clk), .rst_i(rst_n), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_data_i(imem_data), .instr_o(instr), .instr_op_o(instr_op),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .instr_valid_o(instr_valid), .stall_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] p, input logic [31:0] w);
    chk({tag, "_valid"}, instr_valid, 1);
    chk({tag, "_pc"}, pc, p);
    chk({tag, "_instr"}, instr, w);
    chk({tag, "_pc4"}, pc_plus4, p + 32'd4);
    chk({tag, "_op"}, instr_op, w[31:26]);
  endtask

  initial begin
    #12;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pc4", pc_plus4, 4);
    chk("rst_addr", imem_addr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_req", imem_req, 0);
    step();
    chk("first_req", imem_req, 1);
    // zero-wait streaming 0..12
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_data = mem(4 * i);
      chk("stream_addr", imem_addr, 4 * i);
      step();
      chk_out("stream", 4 * i, mem(4 * i));
    end
    imem_ack = 1'b0;
    step();
    chk("drain_valid", instr_valid, 0);
    // stall with skid: 0x10 in output, 0x14 into skid
    imem_ack = 1'b1;
    imem_data = mem(32'h10);
    step();
    chk_out("s10", 32'h10, mem(32'h10));
    stall = 1'b1;
    imem_data = mem(32'h14);
    chk("s14_addr", imem_addr, 32'h14);
    step();
    imem_ack = 1'b0;
    chk("skid_req", imem_req, 0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_pc", pc, 32'h10);
      step();
      chk("hold_req", imem_req, 0);
    end
    chk_out("hold", 32'h10, mem(32'h10));
    stall = 1'b0;
    step();
    chk_out("s14", 32'h14, mem(32'h14));
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h18);
    // variable latency: ack on the third request cycle
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 3; d++) begin
        chk("vl_addr", imem_addr, 32'h18 + 4 * k);
        chk("vl_req", imem_req, 1);
        if (d > 0) chk("vl_gap", instr_valid, 0);
        if (d == 2) begin
          imem_ack = 1'b1;
          imem_data = mem(32'h18 + 4 * k);
        end
        step();
        imem_ack = 1'b0;
      end
      chk_out("vl", 32'h18 + 4 * k, mem(32'h18 + 4 * k));
    end
    // redirect while 0x20 is pending
    chk("rw_addr", imem_addr, 32'h20);
    redirect = 1'b1;
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    chk("rw_valid", instr_valid, 0);
    chk("rw_kill_req", imem_req, 1);
    step();
    chk("rw_valid2", instr_valid, 0);
    imem_ack = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("rw_discard", instr_valid, 0);
    chk("rw_req", imem_req, 1);
    chk("rw_addr_new", imem_addr, 32'h400);
    imem_ack = 1'b1;
    imem_data = mem(32'h400);
    step();
    imem_ack = 1'b0;
    chk_out("rw", 32'h400, mem(32'h400));
    // redirect coincident with ack while stalled
    stall = 1'b1;
    imem_ack = 1'b1;
    imem_data = 32'h1234_5678;
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    imem_ack = 1'b0;
    stall = 1'b0;
    chk("rc_valid", instr_valid, 0);
    chk("rc_req", imem_req, 1);
    chk("rc_addr", imem_addr, 32'h100);
    imem_ack = 1'b1;
    imem_data = mem(32'h100);
    step();
    chk_out("rc", 32'h100, mem(32'h100));
    // wrap at top of address space
    imem_data = 32'h0BAD_0BAD;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_valid", instr_valid, 0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    imem_data = mem(32'hFFFF_FFFC);
    step();
    chk_out("wr_top", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC));
    chk("wr_addr0", imem_addr, 0);
    imem_data = mem(0);
    step();
    imem_ack = 1'b0;
    chk_out("wr_zero", 0, mem(0));
    // asynchronous reset during a pending request
    chk("mr_pending", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req", imem_req, 0);
    chk("mr_valid", instr_valid, 0);
    chk("mr_pc", pc, 0);
    chk("mr_pc4", pc_plus4, 4);
    chk("mr_instr", instr, 0);
    step();
    step();
    rst_n = 1'b1;
    chk("mr_idle", imem_req, 0);
    step();
    chk("mr_req2", imem_req, 1);
    chk("mr_addr", imem_addr, 0);
    imem_ack = 1'b1;
    imem_data = mem(0);
    step();
    imem_ack = 1'b0;
    chk_out("mr", 0, mem(0));
    // randomized traffic: consumed instructions must follow the PC stream, restarting at each redirect target
    exp_pc = 0;
    wcnt = 0;
    dly = $urandom_range(0, 3);
    dirty = 0;
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = $urandom_range(0, 3) == 0;
      redir = $urandom_range(0, 24) == 0;
      tgt = $urandom;
      if (!redir && instr_valid && !stall) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_instr", instr, mem(exp_pc));
        chk("rnd_pc4", pc_plus4, exp_pc + 32'd4);
        chk("rnd_op", instr_op, instr[31:26]);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      if (redir) exp_pc = tgt & ~32'd3;
      redirect = redir;
      redirect_pc = tgt;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (wcnt == 0) raddr = imem_addr;
        else if (!dirty) chk("rnd_addr_stable", imem_addr, raddr);
        imem_data = mem(imem_addr);
        if (wcnt == dly) begin
          imem_ack = 1'b1;
          wcnt = 0;
          dly = $urandom_range(0, 3);
          dirty = 0;
        end else begin
          wcnt++;
          if (redir) dirty = 1;
        end
      end
      step();
    end
    redirect = 1'b0;
    imem_ack = 1'b0;
    chk("rnd_progress", n > 200, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
